issue_unit: RTL

Issue stage directly downstream of the reservation station. It consumes the RS's registered `insn_for_ex` candidate, latches one ready instruction into an issue register, and presents it to the selected functional unit through a valid/ready handshake. When it accepts an instruction, it drives `clear`/`clear_tag` back to the RS so the entry is retired. It also suppresses the one-cycle stale duplicate the RS presents after every clear, and keeps issue and stall statistics.

---
 rtl/issue_unit_if.sv | 49 ++++
 rtl/issue_unit.sv | 121 ++++++++++++
 2 files changed

// File: rtl/issue_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : issue_unit_pkg / issue_unit_if
//  Description : Shared instruction types for the issue stage, and the
//                functional-unit issue bus (one-hot request, shared payload,
//                per-FU ready).
//                Ports of issue_unit_if:
//                  fu_valid [3:0]  one-hot issue request (0=ALU 1=BTU 2=MULT 3=LSU)
//                  fu_ready [3:0]  per-FU accept, same bit order
//                  fu_insn         issued instruction, shared by all FUs
//  Revision    : 1.0 - initial release
// ============================================================================

package issue_unit_pkg;

    localparam int ROB_TAG_LEN = 5;

    // Instruction as held by a reservation-station entry.
    typedef struct packed {
        logic [7:0]             opcode;
        logic [15:0]            imm;
        logic                   ready_src1;
        logic                   ready_src2;
        logic [ROB_TAG_LEN-1:0] insn_tag;
        logic [1:0]             fu_type;
    } INST_RS;

    // Candidate presented by the reservation station.
    typedef struct packed {
        logic   valid;
        INST_RS insn;
    } RS_ENTRY;

endpackage

interface issue_unit_if;
    import issue_unit_pkg::*;

    logic [3:0] fu_valid;
    logic [3:0] fu_ready;
    INST_RS     fu_insn;

    // master: the issue unit; slave: the functional units.
    modport master (output fu_valid, output fu_insn, input fu_ready);
    modport slave  (input fu_valid, input fu_insn, output fu_ready);

endinterface

`default_nettype wire

// File: rtl/issue_unit.sv
`default_nettype none
// ============================================================================
//  Module      : issue_unit
//  Description : Issue stage behind the reservation station. Latches one
//                ready candidate into an issue register, offers it to the
//                selected functional unit over a valid/ready handshake,
//                tells the RS to retire the accepted entry, masks the
//                one-cycle stale duplicate the RS shows after a clear, and
//                counts transfers and stall cycles.
//  Ports       :
//    clk          in   system clock
//    reset        in   asynchronous active-low reset
//    rs_insn      in   RS candidate (insn_for_ex)
//    flush        in   synchronous squash
//    fu           bus  issue_unit_if.master (fu_valid/fu_insn out, fu_ready in)
//    clear        out  retire request to the RS (same cycle as accept)
//    clear_tag    out  tag to retire (0 when clear is low)
//    issue_count  out  completed FU transfers (wrapping)
//    stall_count  out  cycles a held instruction waited on fu_ready (wrapping)
//  Revision    : 1.0 - initial release
// ============================================================================

module issue_unit
    import issue_unit_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  wire logic                   clk,
    input  wire logic                   reset,
    input  wire RS_ENTRY                rs_insn,
    input  wire logic                   flush,
    issue_unit_if.master                fu,
    output logic                        clear,
    output logic [ROB_TAG_LEN-1:0]      clear_tag,
    output logic [CNT_WIDTH-1:0]        issue_count,
    output logic [CNT_WIDTH-1:0]        stall_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t                 state;
    INST_RS                 out_insn;
    logic                   sup_valid;
    logic [ROB_TAG_LEN-1:0] sup_tag;

    logic                   out_valid;
    logic [3:0]             fu_sel;
    logic                   transfer;
    logic                   dup;
    logic                   eligible;
    logic                   accept;

    assign out_valid = (state == HOLD);

    always_comb begin
        fu_sel                   = 4'b0000;
        fu_sel[out_insn.fu_type] = 1'b1;
    end

    assign fu.fu_valid = (out_valid && !flush) ? fu_sel : 4'b0000;
    assign fu.fu_insn  = out_insn;
    assign transfer    = |(fu.fu_valid & fu.fu_ready);

    // The RS output register still shows the entry retired last cycle.
    assign dup      = sup_valid && (rs_insn.insn.insn_tag == sup_tag);

    // Gating with reset keeps clear low while the block is held in reset,
    // whatever the RS happens to present.
    assign eligible = reset && rs_insn.valid && rs_insn.insn.ready_src1
                      && rs_insn.insn.ready_src2 && !dup;
    assign accept   = eligible && (!out_valid || transfer) && !flush;

    assign clear     = accept;
    assign clear_tag = accept ? rs_insn.insn.insn_tag : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= EMPTY;
            out_insn    <= '0;
            sup_valid   <= 1'b0;
            sup_tag     <= '0;
            issue_count <= '0;
            stall_count <= '0;
        end else begin
            if (flush) begin
                state     <= EMPTY;
                sup_valid <= 1'b0;
            end else begin
                case (state)
                    EMPTY:   if (accept) state <= HOLD;
                    // Transfer plus accept in one cycle stays in HOLD with
                    // the new instruction: no bubble.
                    HOLD:    if (transfer && !accept) state <= EMPTY;
                    default: state <= EMPTY;
                endcase

                sup_valid <= accept;
                if (accept) begin
                    sup_tag  <= rs_insn.insn.insn_tag;
                    out_insn <= rs_insn.insn;
                end
            end

            // fu_valid is forced low under flush, so neither counter moves.
            if (transfer) begin
                issue_count <= issue_count + CNT_ONE;
            end
            if (out_valid && !transfer && !flush) begin
                stall_count <= stall_count + CNT_ONE;
            end
        end
    end

endmodule

`default_nettype wire
